// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator: pixel coordinates, line/frame strobes and a frame
// counter, with sync/blank delayed by PIPE_DELAY pixel steps to match a pipelined renderer.
module vga_timing_pipe #(
  parameter int unsigned HACTIVE    = 640,
  parameter int unsigned HFP        = 16,
  parameter int unsigned HSYNC      = 96,
  parameter int unsigned HBP        = 48,
  parameter int unsigned VACTIVE    = 480,
  parameter int unsigned VFP        = 10,
  parameter int unsigned VSYNC      = 2,
  parameter int unsigned VBP        = 33,
  parameter logic        HPOL       = 1'b0,
  parameter logic        VPOL       = 1'b0,
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned CW         = 10,
  parameter int unsigned FCW        = 16
) (
  input  logic           vgaclk,
  input  logic           reset,
  input  logic           pix_ce,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           hsync,
  output logic           vsync,
  output logic           blank_b,
  output logic           sync_b,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  localparam int unsigned HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int unsigned VTOTAL = VACTIVE + VFP + VSYNC + VBP;

  if (PIPE_DELAY > 15) begin : g_bad_delay
    $error("vga_timing_pipe: PIPE_DELAY must be 0..15");
  end
  if (HTOTAL > (1 << CW) || VTOTAL > (1 << CW)) begin : g_bad_width
    $error("vga_timing_pipe: HTOTAL/VTOTAL exceed 2^CW");
  end

  // One extra bit so a total of exactly 2^CW still fits in the compare constants
  localparam logic [CW:0]   H_ACT  = (CW+1)'(HACTIVE);
  localparam logic [CW:0]   H_SS   = (CW+1)'(HACTIVE + HFP);
  localparam logic [CW:0]   H_SE   = (CW+1)'(HACTIVE + HFP + HSYNC);
  localparam logic [CW:0]   V_ACT  = (CW+1)'(VACTIVE);
  localparam logic [CW:0]   V_SS   = (CW+1)'(VACTIVE + VFP);
  localparam logic [CW:0]   V_SE   = (CW+1)'(VACTIVE + VFP + VSYNC);
  localparam logic [CW-1:0] H_LAST = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VTOTAL - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } dec_t;

  dec_t        raw;
  dec_t        del;
  logic [CW:0] xe;
  logic [CW:0] ye;

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        if (x == H_LAST) begin
          x          <= '0;
          line_start <= 1'b1;
          if (y == V_LAST) begin
            y           <= '0;
            frame_start <= 1'b1;
            frame_count <= frame_count + FCW'(1);
          end else begin
            y <= y + CW'(1);
          end
        end else begin
          x <= x + CW'(1);
        end
      end
    end
  end

  assign xe = {1'b0, x};
  assign ye = {1'b0, y};

  always_comb begin
    raw     = '0;
    raw.act = (xe < H_ACT) && (ye < V_ACT);
    raw.hs  = (xe >= H_SS) && (xe < H_SE);
    raw.vs  = (ye >= V_SS) && (ye < V_SE);
  end

  if (PIPE_DELAY == 0) begin : g_nodelay
    assign del = raw;
  end else begin : g_delay
    dec_t stage [PIPE_DELAY];

    // Stages hold raw "asserted" flags; '0 maps to inactive sync levels and blanked video
    always_ff @(posedge vgaclk) begin
      if (reset) begin
        for (int unsigned i = 0; i < PIPE_DELAY; i++) stage[i] <= '0;
      end else if (pix_ce) begin
        stage[0] <= raw;
        for (int unsigned i = 1; i < PIPE_DELAY; i++) stage[i] <= stage[i-1];
      end
    end

    assign del = stage[PIPE_DELAY-1];
  end

  assign hsync   = del.hs ? HPOL : ~HPOL;
  assign vsync   = del.vs ? VPOL : ~VPOL;
  assign blank_b = del.act;
  assign sync_b  = 1'b0;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench for vga_timing_pipe: several parameterisations exercised with
// a hand-computed vector table and arithmetic expected-value sequences.
module tb_vga_timing_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // defaults, PIPE_DELAY = 2
  logic rst_d = 1'b1, ce_d = 1'b1;
  logic [9:0] x_d, y_d;
  logic hs_d, vs_d, bl_d, sb_d, ls_d, fs_d;
  logic [15:0] fc_d;
  vga_timing_pipe u_def (
    .vgaclk(clk), .reset(rst_d), .pix_ce(ce_d), .x(x_d), .y(y_d), .hsync(hs_d), .vsync(vs_d),
    .blank_b(bl_d), .sync_b(sb_d), .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d));

  // short lines, default vertical timing
  logic rst_v = 1'b1, ce_v = 1'b1;
  logic [9:0] x_v, y_v;
  logic hs_v, vs_v, bl_v, sb_v, ls_v, fs_v;
  logic [15:0] fc_v;
  vga_timing_pipe #(.HACTIVE(8), .HFP(2), .HSYNC(2), .HBP(4)) u_vs (
    .vgaclk(clk), .reset(rst_v), .pix_ce(ce_v), .x(x_v), .y(y_v), .hsync(hs_v), .vsync(vs_v),
    .blank_b(bl_v), .sync_b(sb_v), .line_start(ls_v), .frame_start(fs_v), .frame_count(fc_v));

  // small mode, FCW = 2
  logic rst_s = 1'b1, ce_s = 1'b1;
  logic [9:0] x_s, y_s;
  logic hs_s, vs_s, bl_s, sb_s, ls_s, fs_s;
  logic [1:0] fc_s;
  vga_timing_pipe #(.HACTIVE(4), .HFP(1), .HSYNC(1), .HBP(1), .VACTIVE(2), .VFP(1), .VSYNC(1),
                    .VBP(1), .FCW(2)) u_sm (
    .vgaclk(clk), .reset(rst_s), .pix_ce(ce_s), .x(x_s), .y(y_s), .hsync(hs_s), .vsync(vs_s),
    .blank_b(bl_s), .sync_b(sb_s), .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s));

  // positive polarity, no delay
  logic rst_p = 1'b1, ce_p = 1'b1;
  logic [9:0] x_p, y_p;
  logic hs_p, vs_p, bl_p, sb_p, ls_p, fs_p;
  logic [15:0] fc_p;
  vga_timing_pipe #(.HPOL(1'b1), .VPOL(1'b1), .PIPE_DELAY(0)) u_pol (
    .vgaclk(clk), .reset(rst_p), .pix_ce(ce_p), .x(x_p), .y(y_p), .hsync(hs_p), .vsync(vs_p),
    .blank_b(bl_p), .sync_b(sb_p), .line_start(ls_p), .frame_start(fs_p), .frame_count(fc_p));

  // mid-frame reset, 304 x 230 totals, PIPE_DELAY = 3
  logic rst_r = 1'b1, ce_r = 1'b1;
  logic [9:0] x_r, y_r;
  logic hs_r, vs_r, bl_r, sb_r, ls_r, fs_r;
  logic [15:0] fc_r;
  vga_timing_pipe #(.HACTIVE(240), .HFP(16), .HSYNC(32), .HBP(16), .VACTIVE(220), .VFP(4),
                    .VSYNC(2), .VBP(4), .PIPE_DELAY(3)) u_rst (
    .vgaclk(clk), .reset(rst_r), .pix_ce(ce_r), .x(x_r), .y(y_r), .hsync(hs_r), .vsync(vs_r),
    .blank_b(bl_r), .sync_b(sb_r), .line_start(ls_r), .frame_start(fs_r), .frame_count(fc_r));

  typedef struct {
    logic rst;
    logic ce;
    int   ex;
    int   ey;
    logic ehs;
    logic ebl;
    logic els;
    logic efs;
  } vec_t;

  vec_t tbl [21];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 5, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 5, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 6, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 6, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 2, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0};

    fork
      begin : mid_frame_reset
        tick();
        rst_r = 1'b0;
        repeat (200 * 304 + 300) tick();
        check("rst_pre_x", x_r, 300);
        check("rst_pre_y", y_r, 200);
        rst_r = 1'b1;
        tick();
        check("rst_x", x_r, 0);
        check("rst_y", y_r, 0);
        check("rst_hsync", hs_r, 1);
        check("rst_vsync", vs_r, 1);
        check("rst_blank_b", bl_r, 0);
        check("rst_frame_start", fs_r, 0);
        check("rst_line_start", ls_r, 0);
        rst_r = 1'b0;
        tick();
        check("rst_rel1_blank_b", bl_r, 0);
        check("rst_rel1_frame_start", fs_r, 0);
        tick();
        check("rst_rel2_blank_b", bl_r, 0);
        tick();
        check("rst_rel3_blank_b", bl_r, 1);
      end
      begin : main_seq
        int p;
        int line;
        int xx;

        // default mode: counting, line strobe, hsync/blank delayed by 2 steps
        tick();
        check("def_rst_x", x_d, 0);
        check("def_rst_y", y_d, 0);
        check("def_rst_fc", fc_d, 0);
        check("def_rst_ls", ls_d, 0);
        check("def_rst_fs", fs_d, 0);
        check("def_rst_hsync", hs_d, 1);
        check("def_rst_vsync", vs_d, 1);
        check("def_rst_blank_b", bl_d, 0);
        check("def_sync_b", sb_d, 0);
        rst_d = 1'b0;
        for (int n = 1; n <= 1700; n++) begin
          tick();
          p = n - 2;
          check("def_x", x_d, n % 800);
          check("def_y", y_d, n / 800);
          check("def_line_start", ls_d, (n % 800 == 0) ? 1 : 0);
          check("def_hsync", hs_d, (p >= 0 && p % 800 >= 656 && p % 800 < 752) ? 0 : 1);
          check("def_blank_b", bl_d, (p >= 0 && p % 800 < 640) ? 1 : 0);
          check("def_vsync", vs_d, 1);
        end

        // vertical sync window and first frame wrap
        tick();
        rst_v = 1'b0;
        for (int n = 1; n <= 8402; n++) begin
          tick();
          p = n - 2;
          line = (p < 0) ? 0 : (p / 16) % 525;
          check("vs_vsync", vs_v, (p >= 0 && line >= 490 && line < 492) ? 0 : 1);
          check("vs_frame_start", fs_v, (n % 8400 == 0) ? 1 : 0);
          check("vs_frame_count", fc_v, n / 8400);
          if (n == 8400) begin
            check("vs_wrap_x", x_v, 0);
            check("vs_wrap_y", y_v, 0);
            check("vs_wrap_ls", ls_v, 1);
          end
        end

        // small mode with 50% pix_ce, table-driven
        for (int i = 0; i < 21; i++) begin
          rst_s = tbl[i].rst;
          ce_s  = tbl[i].ce;
          tick();
          check("sm_x", x_s, tbl[i].ex);
          check("sm_y", y_s, tbl[i].ey);
          check("sm_hsync", hs_s, tbl[i].ehs);
          check("sm_blank_b", bl_s, tbl[i].ebl);
          check("sm_line_start", ls_s, tbl[i].els);
          check("sm_frame_start", fs_s, tbl[i].efs);
        end

        // small mode frame counter wrap with FCW = 2
        rst_s = 1'b1;
        ce_s  = 1'b1;
        tick();
        check("fc_rst", fc_s, 0);
        rst_s = 1'b0;
        for (int f = 1; f <= 5; f++) begin
          repeat (34) tick();
          check("fc_pre_fs", fs_s, 0);
          tick();
          check("fc_fs", fs_s, 1);
          check("fc_ls", ls_s, 1);
          check("fc_x", x_s, 0);
          check("fc_y", y_s, 0);
          check("fc_count", fc_s, f % 4);
        end

        // positive polarity, combinational decode
        tick();
        check("pol_rst_hsync", hs_p, 0);
        check("pol_rst_vsync", vs_p, 0);
        check("pol_rst_blank_b", bl_p, 1);
        rst_p = 1'b0;
        for (int n = 1; n <= 800; n++) begin
          tick();
          xx = n % 800;
          check("pol_x", x_p, xx);
          check("pol_hsync", hs_p, (xx >= 656 && xx < 752) ? 1 : 0);
          check("pol_blank_b", bl_p, (xx < 640) ? 1 : 0);
        end
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
Parametrised successor to the fixed 640x480 VGA timing controller. Generates pixel coordinates plus hsync/vsync/blank_b for any mode, given porch and sync widths as parameters. Sync and blank are delayed by a programmable number of pixel steps so they line up with a pipelined pixel generator such as draw_board. Also provides a pixel clock-enable input, line and frame strobes, and a frame counter for animation logic.

Parameters:
HACTIVE, 640, visible pixels per line
HFP, 16, horizontal front porch (pixels)
HSYNC, 96, hsync pulse width (pixels)
HBP, 48, horizontal back porch (pixels)
VACTIVE, 480, visible lines per frame
VFP, 10, vertical front porch (lines)
VSYNC, 2, vsync pulse width (lines)
VBP, 33, vertical back porch (lines)
HPOL, 0, hsync asserted level (0 = active-low)
VPOL, 0, vsync asserted level (0 = active-low)
PIPE_DELAY, 2, pixel-generator latency in pixel steps (0..15)
CW, 10, coordinate counter width; HTOTAL and VTOTAL must each be <= 2^CW
FCW, 16, frame counter width

Ports:
vgaclk  in  1  pixel-domain clock
reset  in  1  synchronous, active-high reset
pix_ce  in  1  pixel step enable; 1 every cycle when vgaclk is the pixel clock
x  out  CW  current horizontal count, 0..HTOTAL-1
y  out  CW  current vertical count, 0..VTOTAL-1
hsync  out  1  delayed horizontal sync, polarity HPOL
vsync  out  1  delayed vertical sync, polarity VPOL
blank_b  out  1  delayed active-video flag (1 = visible pixel)
sync_b  out  1  constant 0 (DAC composite sync unused)
line_start  out  1  one-vgaclk pulse when x returns to 0
frame_start  out  1  one-vgaclk pulse when (x,y) returns to (0,0)
frame_count  out  FCW  completed-frame counter, wraps modulo 2^FCW

Behaviour:
- Derived totals: HTOTAL = HACTIVE+HFP+HSYNC+HBP (default 800); VTOTAL = VACTIVE+VFP+VSYNC+VBP (default 525).
- Reset has priority over pix_ce. On the reset cycle the following are set:
  - x = 0, y = 0, frame_count = 0, line_start = 0, frame_start = 0.
  - Every delay stage is set to its inactive value: hsync = ~HPOL, vsync = ~VPOL, blank_b = 0.
- Reset mid-frame takes effect the next edge. It produces no frame_start or line_start.
- Counters are registered and change only on vgaclk edges with pix_ce = 1. With pix_ce = 0, all state holds and the strobes are 0.
- Counter advance: x increments. At x = HTOTAL-1, x wraps to 0 and y increments. At (HTOTAL-1, VTOTAL-1), both wrap to 0 and frame_count increments with wrap.
- line_start is registered and high for exactly one vgaclk after any x wrap. It therefore coincides with x = 0.
- frame_start is registered and high for exactly one vgaclk after the (x,y) wrap. line_start is also high on that cycle.
- Raw decode (combinational from x and y):
  - active = (x < HACTIVE) && (y < VACTIVE)
  - hs_raw asserted when HACTIVE+HFP <= x < HACTIVE+HFP+HSYNC
  - vs_raw asserted when VACTIVE+VFP <= y < VACTIVE+VFP+VSYNC
- Delay line: PIPE_DELAY registers, shifted only on pix_ce = 1. The outputs equal the raw decode from PIPE_DELAY pixel steps earlier.
- With PIPE_DELAY = 0 the outputs are the combinational decode of the current x and y.
- Consequence: a pixel generator fed x and y with PIPE_DELAY registered stages produces colour aligned with blank_b.
- Output levels: hsync = HPOL when the delayed hs_raw is set, otherwise ~HPOL. vsync follows the same rule with VPOL.
- Elaboration-time error if PIPE_DELAY > 15, or if HTOTAL or VTOTAL exceeds 2^CW.

Test Plan:
- Reset, then pix_ce = 1 constantly with defaults:
  - x counts 0..799, then wraps.
  - line_start is high on the cycle x = 0.
  - After 420000 cycles, frame_start pulses once, frame_count = 1, and (x,y) = (0,0).
- Defaults, PIPE_DELAY = 2:
  - hsync is 0 exactly for the 96 cycles starting 2 steps after x = 656.
  - blank_b falls 2 steps after x = 640.
  - vsync is low for 2 lines, starting at line 490 + 2 steps.
- Toggle pix_ce at 50% with a small mode (HACTIVE=4, HFP=1, HSYNC=1, HBP=1, VACTIVE=2, VFP/VSYNC/VBP=1):
  - x advances only on ce cycles, so a 7-step line takes 14 cycles.
  - Strobes last one cycle.
  - hsync and blank_b hold between enables.
- Assert reset at (x,y) = (300,200) with PIPE_DELAY = 3:
  - Next cycle: x = y = 0, hsync = vsync = 1, blank_b = 0, and no frame_start pulse.
  - blank_b rises 3 steps after reset release.
- HPOL = VPOL = 1, PIPE_DELAY = 0: hsync is high combinationally for x in 656..751, and low at reset.
- FCW = 2, small mode: after 4 frames frame_count reads 0, 1, 2, 3, then 0.
